// File: rtl/ps2_scan_receiver.sv
// PS/2 keyboard receiver: deserialises Set-2 frames, strips E0/F0/E1 prefixes, tracks shift.
// Optional caps-lock tracking is compiled in with `define KEYB_CAPSLOCK_EN.
module ps2_scan_receiver #(
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       extended,
    output logic       letter_case,
    output logic       key_valid,
    output logic       frame_error,
    output logic       caps_lock
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_SKIP    = 3'd4
    } pfx_state_t;

    logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic          filt_q, filt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          edge_fall;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [8:0]    shift_q, shift_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          byte_vld_q, byte_vld_d;
    logic [7:0]    byte_q, byte_d;
    logic          ferr_q, ferr_d;
    pfx_state_t    state_q, state_d;
    logic [2:0]    skip_q, skip_d;
    logic          kv_q, kv_d;
    logic [7:0]    scan_q, scan_d;
    logic          ext_q, ext_d;
    logic          shl_q, shl_d, shr_q, shr_d;
    logic          lc_q, lc_d;
    logic          ignored;

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= ps2_clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_data;
            dat_s2_q <= dat_s1_q;
        end
    end

    // Filtered clock follows the synchronised clock only after FILTER_LEN differing samples in a row.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (clk_s2_q != filt_q) begin
            if (fcnt_q == FW'(FILTER_LEN - 1)) filt_d = clk_s2_q;
            else                               fcnt_d = fcnt_q + 1'b1;
        end
    end

    assign edge_fall = filt_q & ~filt_d;

    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        byte_d     = byte_q;
        byte_vld_d = 1'b0;
        ferr_d     = 1'b0;
        to_cnt_d   = (to_cnt_q == TW'(TIMEOUT_CYCLES)) ? to_cnt_q : to_cnt_q + 1'b1;
        if (edge_fall) begin
            to_cnt_d = '0;
            if (bit_cnt_q == 4'd0) begin
                // A high start bit is dropped at once so the receiver realigns on the next low one.
                if (dat_s2_q) ferr_d    = 1'b1;
                else          bit_cnt_d = 4'd1;
            end else if (bit_cnt_q == 4'd10) begin
                bit_cnt_d = 4'd0;
                if (dat_s2_q && (^shift_q)) begin
                    byte_vld_d = 1'b1;
                    byte_d     = shift_q[7:0];
                end else begin
                    ferr_d = 1'b1;
                end
            end else begin
                shift_d   = {dat_s2_q, shift_q[8:1]};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end else if ((to_cnt_q == TW'(TIMEOUT_CYCLES)) && (bit_cnt_q != 4'd0)) begin
            bit_cnt_d = 4'd0;
            ferr_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            filt_q     <= 1'b1;
            fcnt_q     <= '0;
            bit_cnt_q  <= 4'd0;
            shift_q    <= '0;
            to_cnt_q   <= '0;
            byte_vld_q <= 1'b0;
            byte_q     <= 8'h00;
            ferr_q     <= 1'b0;
        end else begin
            filt_q     <= filt_d;
            fcnt_q     <= fcnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            to_cnt_q   <= to_cnt_d;
            byte_vld_q <= byte_vld_d;
            byte_q     <= byte_d;
            ferr_q     <= ferr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            skip_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
        end
    end

    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        if (byte_vld_q) begin
            case (state_q)
                ST_IDLE: begin
                    if (byte_q == 8'hE0)      state_d = ST_EXT;
                    else if (byte_q == 8'hF0) state_d = ST_BRK;
                    else if (byte_q == 8'hE1) begin
                        state_d = ST_SKIP;
                        skip_d  = 3'd7;
                    end
                end
                ST_EXT:     state_d = (byte_q == 8'hF0) ? ST_EXT_BRK : ST_IDLE;
                ST_BRK:     state_d = ST_IDLE;
                ST_EXT_BRK: state_d = ST_IDLE;
                ST_SKIP: begin
                    skip_d = skip_q - 3'd1;
                    if (skip_q == 3'd1) state_d = ST_IDLE;
                end
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        case (byte_q)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: ignored = 1'b1;
            default:                                         ignored = 1'b0;
        endcase
    end

`ifdef KEYB_CAPSLOCK_EN
    logic caps_q, caps_d, held_q, held_d;
`endif

    always_comb begin
        kv_d   = 1'b0;
        scan_d = scan_q;
        ext_d  = ext_q;
        shl_d  = shl_q;
        shr_d  = shr_q;
`ifdef KEYB_CAPSLOCK_EN
        caps_d = caps_q;
        held_d = held_q;
`endif
        if (byte_vld_q) begin
            case (state_q)
                ST_IDLE: begin
                    if (byte_q == 8'hE0 || byte_q == 8'hF0 || byte_q == 8'hE1 || ignored) begin
                        kv_d = 1'b0;
                    end else if (byte_q == 8'h12) begin
                        shl_d = 1'b1;
                    end else if (byte_q == 8'h59) begin
                        shr_d = 1'b1;
`ifdef KEYB_CAPSLOCK_EN
                    end else if (byte_q == 8'h58) begin
                        // Toggle once per physical press; typematic repeats are swallowed.
                        if (!held_q) caps_d = ~caps_q;
                        held_d = 1'b1;
`endif
                    end else begin
                        kv_d   = 1'b1;
                        scan_d = byte_q;
                        ext_d  = 1'b0;
                    end
                end
                ST_EXT: begin
                    if (byte_q != 8'hF0 && byte_q != 8'h12 && byte_q != 8'h59) begin
                        kv_d   = 1'b1;
                        scan_d = byte_q;
                        ext_d  = 1'b1;
                    end
                end
                ST_BRK: begin
                    if (byte_q == 8'h12) shl_d = 1'b0;
                    if (byte_q == 8'h59) shr_d = 1'b0;
`ifdef KEYB_CAPSLOCK_EN
                    if (byte_q == 8'h58) held_d = 1'b0;
`endif
                end
                default: kv_d = 1'b0;
            endcase
        end
`ifdef KEYB_CAPSLOCK_EN
        lc_d = (shl_d | shr_d) ^ caps_d;
`else
        lc_d = shl_d | shr_d;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            kv_q   <= 1'b0;
            scan_q <= 8'h00;
            ext_q  <= 1'b0;
            shl_q  <= 1'b0;
            shr_q  <= 1'b0;
            lc_q   <= 1'b0;
        end else begin
            kv_q   <= kv_d;
            scan_q <= scan_d;
            ext_q  <= ext_d;
            shl_q  <= shl_d;
            shr_q  <= shr_d;
            lc_q   <= lc_d;
        end
    end

`ifdef KEYB_CAPSLOCK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            caps_q <= 1'b0;
            held_q <= 1'b0;
        end else begin
            caps_q <= caps_d;
            held_q <= held_d;
        end
    end
    assign caps_lock = caps_q;
`else
    assign caps_lock = 1'b0;
`endif

    assign scan_code   = scan_q;
    assign extended    = ext_q;
    assign letter_case = lc_q;
    assign key_valid   = kv_q;
    assign frame_error = ferr_q;

endmodule
